// File: rtl/local_ni_pkg.sv
// Shared types and sizing for the PE-to-router network interface.
package local_ni_pkg;

    localparam int ADDR_W    = 8;
    localparam int FLIT_W    = 32;
    localparam int PAY_W     = FLIT_W - ADDR_W;
    localparam int RTR_DEPTH = 4;
    localparam int EJ_DEPTH  = 4;
    localparam int CR_W      = $clog2(RTR_DEPTH + 1);
    localparam int EJ_CW     = $clog2(EJ_DEPTH + 1);

    localparam int ERR_EJ_OVF   = 0;
    localparam int ERR_CR_OVF   = 1;
    localparam int ERR_MISROUTE = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [PAY_W-1:0]  payload;
    } flit_t;

    typedef enum logic {
        IDLE,
        HOLD
    } ni_state_e;

    function automatic flit_t make_flit(input logic [ADDR_W-1:0] dest,
                                        input logic [PAY_W-1:0]  payload);
        flit_t f;
        f.dest    = dest;
        f.payload = payload;
        return f;
    endfunction

endpackage

// File: rtl/local_ni_if.sv
// PE/router handshake bundle of the network interface; names are from the NI's point of view.
interface local_ni_if;
    import local_ni_pkg::*;

    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [ADDR_W-1:0] tx_dest_i;
    logic [PAY_W-1:0]  tx_data_i;
    logic [FLIT_W-1:0] inj_flit_o;
    logic              inj_valid_o;
    logic              inj_cr_i;
    logic [FLIT_W-1:0] ej_flit_i;
    logic              ej_valid_i;
    logic              ej_cr_o;
    logic              rx_valid_o;
    logic              rx_ready_i;
    logic [FLIT_W-1:0] rx_flit_o;

    modport slave (
        input  tx_valid_i, tx_dest_i, tx_data_i, inj_cr_i,
               ej_flit_i, ej_valid_i, rx_ready_i,
        output tx_ready_o, inj_flit_o, inj_valid_o, ej_cr_o,
               rx_valid_o, rx_flit_o
    );

    modport master (
        output tx_valid_i, tx_dest_i, tx_data_i, inj_cr_i,
               ej_flit_i, ej_valid_i, rx_ready_i,
        input  tx_ready_o, inj_flit_o, inj_valid_o, ej_cr_o,
               rx_valid_o, rx_flit_o
    );

endinterface

// File: rtl/local_ni_fifo.sv
// First-word-fall-through FIFO; a simultaneous write and read is accepted even when full.
module local_ni_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/local_ni.sv
// Network interface between a PE and the router local port: credit-gated inject, buffered eject.
module local_ni
    import local_ni_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] my_addr_i,
    local_ni_if.slave         bus,
    output logic [CR_W-1:0]   credits_o,
    output logic [2:0]        err_o
);

    ni_state_e        state_q, state_d;
    flit_t            hold_q, hold_d;
    flit_t            inj_flit_q, inj_flit_d;
    logic             inj_valid_q, inj_valid_d;
    logic [CR_W-1:0]  credits_q, credits_d;
    logic [2:0]       err_q, err_d;
    logic             ej_cr_q;
    logic             launch, tx_ready, cr_ovf;

    flit_t            ej_flit, fifo_head;
    logic             fifo_full, fifo_empty, pop, ej_accept, ej_drop, misroute;
    logic [EJ_CW-1:0] fifo_count;

    // A launch needs a held flit and at least one free slot in the router buffer.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        inj_flit_d  = inj_flit_q;
        inj_valid_d = 1'b0;
        launch      = (state_q == HOLD) && (credits_q != '0);
        tx_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (bus.tx_valid_i) begin
                    hold_d  = make_flit(bus.tx_dest_i, bus.tx_data_i);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                tx_ready = launch;
                if (launch) begin
                    inj_flit_d  = hold_q;
                    inj_valid_d = 1'b1;
                    if (bus.tx_valid_i) hold_d = make_flit(bus.tx_dest_i, bus.tx_data_i);
                    else                state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        cr_ovf    = 1'b0;
        if (launch && !bus.inj_cr_i) begin
            credits_d = credits_q - CR_W'(1);
        end else if (!launch && bus.inj_cr_i) begin
            if (credits_q == CR_W'(RTR_DEPTH)) cr_ovf = 1'b1;
            else                               credits_d = credits_q + CR_W'(1);
        end
    end

    // A write into a full FIFO survives only if the PE pops in the same cycle.
    assign ej_flit   = bus.ej_flit_i;
    assign pop       = !fifo_empty && bus.rx_ready_i;
    assign ej_accept = bus.ej_valid_i && (!fifo_full || pop);
    assign ej_drop   = bus.ej_valid_i && fifo_full && !pop;
    assign misroute  = ej_accept && (ej_flit.dest != my_addr_i);

    always_comb begin
        err_d               = err_q;
        err_d[ERR_EJ_OVF]   = err_q[ERR_EJ_OVF]   | ej_drop;
        err_d[ERR_CR_OVF]   = err_q[ERR_CR_OVF]   | cr_ovf;
        err_d[ERR_MISROUTE] = err_q[ERR_MISROUTE] | misroute;
    end

    local_ni_fifo #(
        .DEPTH (EJ_DEPTH),
        .WIDTH (FLIT_W)
    ) u_ej_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (ej_accept),
        .wr_data_i (bus.ej_flit_i),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            inj_flit_q  <= '0;
            inj_valid_q <= 1'b0;
            credits_q   <= CR_W'(RTR_DEPTH);
            err_q       <= '0;
            ej_cr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            inj_flit_q  <= inj_flit_d;
            inj_valid_q <= inj_valid_d;
            credits_q   <= credits_d;
            err_q       <= err_d;
            ej_cr_q     <= pop;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        fifo_count <= EJ_CW'(EJ_DEPTH) && (fifo_full == (fifo_count == EJ_CW'(EJ_DEPTH))));

    assign bus.tx_ready_o  = tx_ready;
    assign bus.inj_flit_o  = inj_flit_q;
    assign bus.inj_valid_o = inj_valid_q;
    assign bus.ej_cr_o     = ej_cr_q;
    assign bus.rx_valid_o  = !fifo_empty;
    assign bus.rx_flit_o   = fifo_head;
    assign credits_o       = credits_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_local_ni.sv
// Directed-vector bench for local_ni: inject latency/credits, eject FIFO, error flags, async reset.
module tb_local_ni;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] myAddr = 8'h12;
    logic [2:0] credits;
    logic [2:0] err;
    int         vecCount = 0;
    int         errCount = 0;

    local_ni_if bus();

    local_ni dut (
        .clk       (clk),
        .rst       (rst),
        .my_addr_i (myAddr),
        .bus       (bus),
        .credits_o (credits),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic txV, input logic [7:0] dest,
                                 input logic [23:0] data, input logic injCr,
                                 input logic ejV, input logic [31:0] ejFlit,
                                 input logic rxRdy);
        bus.tx_valid_i = txV;
        bus.tx_dest_i  = dest;
        bus.tx_data_i  = data;
        bus.inj_cr_i   = injCr;
        bus.ej_valid_i = ejV;
        bus.ej_flit_i  = ejFlit;
        bus.rx_ready_i = rxRdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_credits"},   32'(credits),         32'd4);
        checkOutput({tag, "_tx_ready"},  32'(bus.tx_ready_o),  32'd1);
        checkOutput({tag, "_inj_valid"}, 32'(bus.inj_valid_o), 32'd0);
        checkOutput({tag, "_inj_flit"},  bus.inj_flit_o,       32'd0);
        checkOutput({tag, "_ej_cr"},     32'(bus.ej_cr_o),     32'd0);
        checkOutput({tag, "_rx_valid"},  32'(bus.rx_valid_o),  32'd0);
        checkOutput({tag, "_err"},       32'(err),             32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.tx_valid_i = 1'b0;
        bus.tx_dest_i  = '0;
        bus.tx_data_i  = '0;
        bus.inj_cr_i   = 1'b0;
        bus.ej_valid_i = 1'b0;
        bus.ej_flit_i  = '0;
        bus.rx_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("rst");

        $display("[TB] single send, 2-cycle latency");
        applyStimulus(1, 8'h21, 24'hABCDEF, 0, 0, 0, 0);
        checkOutput("t1_valid_n1", 32'(bus.inj_valid_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_valid_n2", 32'(bus.inj_valid_o), 32'd1);
        checkOutput("t1_flit",     bus.inj_flit_o,       32'h21ABCDEF);
        checkOutput("t1_credits",  32'(credits),         32'd3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_valid_n3", 32'(bus.inj_valid_o), 32'd0);
        checkOutput("t1_flit_hold", bus.inj_flit_o,      32'h21ABCDEF);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("t1_credits_back", 32'(credits),     32'd4);

        $display("[TB] five back-to-back sends against four credits");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1, 8'h33, 24'(k), 0, 0, 0, 0);
            if (k >= 2) begin
                checkOutput($sformatf("t2_valid_%0d", k - 1), 32'(bus.inj_valid_o), 32'd1);
                checkOutput($sformatf("t2_flit_%0d", k - 1), bus.inj_flit_o,
                            32'h33000000 | 32'(k - 1));
            end
        end
        checkOutput("t2_credits0",  32'(credits),        32'd0);
        checkOutput("t2_ready_low", 32'(bus.tx_ready_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_stall_valid", 32'(bus.inj_valid_o), 32'd0);
        checkOutput("t2_stall_ready", 32'(bus.tx_ready_o),  32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("t2_cr_credits", 32'(credits),         32'd1);
        checkOutput("t2_cr_valid",   32'(bus.inj_valid_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_5th_valid",   32'(bus.inj_valid_o), 32'd1);
        checkOutput("t2_5th_flit",    bus.inj_flit_o,       32'h33000005);
        checkOutput("t2_5th_credits", 32'(credits),         32'd0);

        $display("[TB] simultaneous launch and credit return, credit overflow");
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("t3_credits2", 32'(credits), 32'd2);
        applyStimulus(1, 8'h44, 24'h000010, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("t3_same_cycle_credits", 32'(credits),         32'd2);
        checkOutput("t3_same_cycle_valid",   32'(bus.inj_valid_o), 32'd1);
        checkOutput("t3_same_cycle_flit",    bus.inj_flit_o,       32'h44000010);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("t3_credits4", 32'(credits), 32'd4);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("t3_sat_credits", 32'(credits), 32'd4);
        checkOutput("t3_cr_ovf_err",  32'(err),     32'b010);

        $display("[TB] eject fill, overflow drop, pops");
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'h12000A00 | 32'(k), 0);
        end
        checkOutput("t4_rx_valid", 32'(bus.rx_valid_o), 32'd1);
        checkOutput("t4_head",     bus.rx_flit_o,       32'h12000A01);
        checkOutput("t4_no_cr",    32'(bus.ej_cr_o),    32'd0);
        applyStimulus(0, 0, 0, 0, 1, 32'h12000A05, 0);
        checkOutput("t4_drop_err", 32'(err),         32'b011);
        checkOutput("t4_drop_cr",  32'(bus.ej_cr_o), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("t4_pre_pop_cr_%0d", k), 32'(bus.ej_cr_o),
                        (k == 1) ? 32'd0 : 32'd1);
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            checkOutput($sformatf("t4_pop_cr_%0d", k), 32'(bus.ej_cr_o), 32'd1);
            if (k < 4)
                checkOutput($sformatf("t4_head_%0d", k + 1), bus.rx_flit_o,
                            32'h12000A00 | 32'(k + 1));
        end
        checkOutput("t4_empty", 32'(bus.rx_valid_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_cr_end", 32'(bus.ej_cr_o), 32'd0);

        $display("[TB] write+pop when full, misrouted flit");
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'h12000B00 | 32'(k), 0);
        end
        applyStimulus(0, 0, 0, 0, 1, 32'h12000B05, 1);
        checkOutput("t5_full_head", bus.rx_flit_o,    32'h12000B02);
        checkOutput("t5_full_cr",   32'(bus.ej_cr_o), 32'd1);
        for (int k = 3; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            checkOutput($sformatf("t5_order_%0d", k), bus.rx_flit_o, 32'h12000B00 | 32'(k));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t5_drained", 32'(bus.rx_valid_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 32'h77C0FFEE, 0);
        checkOutput("t5_mis_err",   32'(err),            32'b111);
        checkOutput("t5_mis_valid", 32'(bus.rx_valid_o), 32'd1);
        checkOutput("t5_mis_flit",  bus.rx_flit_o,       32'h77C0FFEE);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t5_mis_cr",    32'(bus.ej_cr_o),    32'd1);
        checkOutput("t5_mis_empty", 32'(bus.rx_valid_o), 32'd0);

        $display("[TB] async reset while holding a flit");
        applyStimulus(1, 8'h55, 24'h000001, 0, 0, 0, 0);
        applyStimulus(1, 8'h55, 24'h000002, 0, 0, 0, 0);
        applyStimulus(1, 8'h55, 24'h000003, 0, 1, 32'h12000C01, 0);
        applyStimulus(1, 8'h55, 24'h000004, 0, 1, 32'h12000C02, 0);
        checkOutput("t6_pre_credits", 32'(credits),         32'd1);
        checkOutput("t6_pre_rx",      32'(bus.rx_valid_o),  32'd1);
        checkOutput("t6_pre_flit",    bus.inj_flit_o,       32'h55000003);
        bus.tx_valid_i = 1'b0;
        bus.ej_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        checkResetState("t6_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t6_no_pulse_%0d", k), 32'(bus.inj_valid_o), 32'd0);
            checkOutput($sformatf("t6_credits_%0d", k),  32'(credits),         32'd4);
        end
        checkOutput("t6_rx_empty", 32'(bus.rx_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
